// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: tree depth and width math,
// and the sideband record that travels with each beat.
package adder_tree_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Operand count after zero-padding to a power of two
   function automatic int pad_cnt(input int n);
      return 1 << clog2(n);
   endfunction

   // Output width of tree level j (level 0 adds the input pairs)
   function automatic int level_width(input int w, input int j);
      return w + j + 1;
   endfunction

   typedef struct packed {
      logic acc_en;
      logic last;
   } sideband_t;

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of pairwise additions; each sum is one bit wider than
// its operands so nothing can overflow. Valid and sideband ride along.
module adder_tree_level
   import adder_tree_pkg::*;
#(
   parameter int p_cnt  = 8,
   parameter int p_w_in = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 en,
   input  logic                                 in_valid,
   input  sideband_t                            in_sb,
   input  logic [p_cnt*p_w_in-1:0]              in_data,
   output logic                                 out_valid,
   output sideband_t                            out_sb,
   output logic [(p_cnt/2)*(p_w_in+1)-1:0]      out_data
);

   localparam int W_OUT = p_w_in + 1;
   localparam int N_OUT = p_cnt / 2;

   logic [N_OUT*W_OUT-1:0] sum_c;

   always_comb begin
      sum_c = '0;
      for (int k = 0; k < N_OUT; k++) begin
         sum_c[k*W_OUT +: W_OUT] = W_OUT'(in_data[2*k*p_w_in +: p_w_in])
                                 + W_OUT'(in_data[(2*k+1)*p_w_in +: p_w_in]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sb    <= '0;
         out_data  <= '0;
      end else if (en) begin
         out_valid <= in_valid;
         out_sb    <= in_sb;
         out_data  <= sum_c;
      end
   end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined masked multi-operand adder with saturating multi-beat accumulation
// and valid/ready flow control. Latency from acceptance to o_valid is L+1.
module adder_tree_pipe
   import adder_tree_pkg::*;
#(
   parameter int p_width   = 16,
   parameter int p_n       = 8,
   parameter int p_acc_ext = 4
) (
   input  logic                                       i_clk,
   input  logic                                       i_rst,
   input  logic                                       i_valid,
   output logic                                       o_ready,
   input  logic [p_n*p_width-1:0]                     i_data,
   input  logic [p_n-1:0]                             i_mask,
   input  logic                                       i_acc_en,
   input  logic                                       i_last,
   output logic                                       o_valid,
   input  logic                                       i_ready,
   output logic [p_width+clog2(p_n)+p_acc_ext-1:0]    o_sum,
   output logic                                       o_sat
);

   localparam int L      = clog2(p_n);
   localparam int NP     = pad_cnt(p_n);
   localparam int W_TREE = level_width(p_width, L - 1);
   localparam int W_SUM  = W_TREE + p_acc_ext;
   localparam int W_EXT  = W_SUM + 1;

   logic                  adv;
   logic [NP*p_width-1:0] cap_d;
   logic [NP*p_width-1:0] cap_data;
   logic                  cap_valid;
   sideband_t             cap_sb;
   logic                  tree_valid;
   sideband_t             tree_sb;
   logic [W_TREE-1:0]     tree_sum;
   logic [W_SUM-1:0]      acc;
   logic                  grp_sat;
   logic [W_EXT-1:0]      acc_sum;
   logic                  clamp;
   logic [W_SUM-1:0]      sat_val;

   // Whole pipe freezes only while a finished result waits downstream
   assign adv     = !(o_valid && !i_ready);
   assign o_ready = adv;

   always_comb begin
      cap_d = '0;
      for (int k = 0; k < p_n; k++) begin
         if (i_mask[k]) cap_d[k*p_width +: p_width] = i_data[k*p_width +: p_width];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cap_valid <= 1'b0;
         cap_sb    <= '0;
         cap_data  <= '0;
      end else if (adv) begin
         cap_valid     <= i_valid;
         cap_sb.acc_en <= i_acc_en;
         cap_sb.last   <= i_last;
         cap_data      <= cap_d;
      end
   end

   for (genvar j = 0; j < L; j++) begin : g_lvl
      localparam int CNT = NP >> j;
      localparam int WI  = p_width + j;
      logic                                      lvl_v;
      sideband_t                                 lvl_sb;
      logic [(CNT/2)*level_width(p_width, j)-1:0] lvl_d;

      if (j == 0) begin : g_src
         adder_tree_level #(.p_cnt(CNT), .p_w_in(WI)) u_level (
            .clk(i_clk), .rst(i_rst), .en(adv),
            .in_valid(cap_valid), .in_sb(cap_sb), .in_data(cap_data),
            .out_valid(lvl_v), .out_sb(lvl_sb), .out_data(lvl_d)
         );
      end else begin : g_src
         adder_tree_level #(.p_cnt(CNT), .p_w_in(WI)) u_level (
            .clk(i_clk), .rst(i_rst), .en(adv),
            .in_valid(g_lvl[j-1].lvl_v), .in_sb(g_lvl[j-1].lvl_sb),
            .in_data(g_lvl[j-1].lvl_d),
            .out_valid(lvl_v), .out_sb(lvl_sb), .out_data(lvl_d)
         );
      end
   end

   assign tree_valid = g_lvl[L-1].lvl_v;
   assign tree_sb    = g_lvl[L-1].lvl_sb;
   assign tree_sum   = g_lvl[L-1].lvl_d;

   assign acc_sum = {1'b0, acc} + W_EXT'(tree_sum);
   assign clamp   = acc_sum[W_SUM];
   assign sat_val = clamp ? {W_SUM{1'b1}} : acc_sum[W_SUM-1:0];

   // Standalone beats bypass the accumulator so an open group is left intact
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         acc     <= '0;
         grp_sat <= 1'b0;
         o_valid <= 1'b0;
         o_sum   <= '0;
         o_sat   <= 1'b0;
      end else if (adv) begin
         o_valid <= 1'b0;
         if (tree_valid) begin
            if (!tree_sb.acc_en) begin
               o_valid <= 1'b1;
               o_sum   <= W_SUM'(tree_sum);
               o_sat   <= 1'b0;
            end else if (!tree_sb.last) begin
               acc     <= sat_val;
               grp_sat <= grp_sat | clamp;
            end else begin
               o_valid <= 1'b1;
               o_sum   <= sat_val;
               o_sat   <= grp_sat | clamp;
               acc     <= '0;
               grp_sat <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Bench for adder_tree_pipe: vector table plus scoreboard for the default
// build, and a narrow-accumulator instance for the saturation sequence.
module tb_adder_tree_pipe;

   localparam int DW = 128;
   localparam int SW = 23;

   logic            i_clk = 1'b0;
   logic            i_rst = 1'b0;
   logic            i_valid = 1'b0;
   logic            vs_s = 1'b0;
   logic [DW-1:0]   i_data = '0;
   logic [7:0]      i_mask = '0;
   logic            i_acc_en = 1'b0;
   logic            i_last = 1'b0;
   logic            i_ready = 1'b1;
   logic            o_ready, o_valid, o_sat;
   logic [SW-1:0]   o_sum;
   logic            ordy_s, ov_s, osat_s;
   logic [19:0]     osum_s;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [SW-1:0] sum;
      logic          sat;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [DW-1:0] data;
      logic [7:0]    mask;
      logic          acc_en;
      logic          last;
      logic          out;
      logic [SW-1:0] sum;
      logic          sat;
   } vec_t;
   vec_t vecs[13];

   adder_tree_pipe dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_data(i_data), .i_mask(i_mask), .i_acc_en(i_acc_en), .i_last(i_last),
      .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_sat(o_sat)
   );

   adder_tree_pipe #(.p_width(16), .p_n(8), .p_acc_ext(1)) dut_s (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(vs_s), .o_ready(ordy_s),
      .i_data(i_data), .i_mask(i_mask), .i_acc_en(i_acc_en), .i_last(i_last),
      .o_valid(ov_s), .i_ready(i_ready), .o_sum(osum_s), .o_sat(osat_s)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic [DW-1:0] ops(input int base, input int step);
      logic [DW-1:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r[k*16 +: 16] = 16'(base + k*step);
      return r;
   endfunction

   function automatic logic [SW-1:0] model(input logic [DW-1:0] d, input logic [7:0] m);
      int s;
      s = 0;
      for (int k = 0; k < 8; k++) if (m[k]) s += int'(d[k*16 +: 16]);
      return SW'(s);
   endfunction

   always @(negedge i_clk) begin
      if (!i_rst && o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_sum", 32'(o_sum), 32'(e.sum));
            chk("out_sat", 32'(o_sat), 32'(e.sat));
         end
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic [7:0] m, input logic ae,
                       input logic la, input logic eo, input logic [SW-1:0] es,
                       input logic esat);
      int n;
      exp_t e;
      n = 0;
      i_data = d; i_mask = m; i_acc_en = ae; i_last = la; i_valid = 1'b1;
      forever begin
         @(negedge i_clk);
         if (o_ready) break;
         n++;
         if (n > 50) begin
            chk("accept_timeout", 0, 1);
            i_valid = 1'b0;
            return;
         end
      end
      if (eo) begin
         e.sum = es;
         e.sat = esat;
         exp_q.push_back(e);
      end
      @(posedge i_clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge i_clk);
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 0);
      repeat (6) @(negedge i_clk);
      @(posedge i_clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{ops(1, 1),     8'hFF, 1'b0, 1'b0, 1'b1, 23'd36,     1'b0};
      vecs[1]  = '{ops(1, 1),     8'h0F, 1'b0, 1'b0, 1'b1, 23'd10,     1'b0};
      vecs[2]  = '{ops(65535, 0), 8'hFF, 1'b0, 1'b0, 1'b1, 23'd524280, 1'b0};
      vecs[3]  = '{ops(0, 0),     8'hFF, 1'b0, 1'b0, 1'b1, 23'd0,      1'b0};
      vecs[4]  = '{ops(1, 1),     8'h00, 1'b0, 1'b0, 1'b1, 23'd0,      1'b0};
      vecs[5]  = '{ops(1, 1),     8'h80, 1'b0, 1'b0, 1'b1, 23'd8,      1'b0};
      vecs[6]  = '{ops(1, 1),     8'hAA, 1'b0, 1'b0, 1'b1, 23'd20,     1'b0};
      vecs[7]  = '{ops(100, 0),   8'hFF, 1'b1, 1'b0, 1'b0, 23'd0,      1'b0};
      vecs[8]  = '{ops(100, 0),   8'hFF, 1'b1, 1'b0, 1'b0, 23'd0,      1'b0};
      vecs[9]  = '{ops(100, 0),   8'hFF, 1'b1, 1'b1, 1'b1, 23'd2400,   1'b0};
      // standalone beat (with a stray last) inside an open group
      vecs[10] = '{ops(1, 1),     8'hFF, 1'b1, 1'b0, 1'b0, 23'd0,      1'b0};
      vecs[11] = '{ops(5, 0),     8'hFF, 1'b0, 1'b1, 1'b1, 23'd40,     1'b0};
      vecs[12] = '{ops(1, 1),     8'h0F, 1'b1, 1'b1, 1'b1, 23'd46,     1'b0};

      #1 i_rst = 1'b1;
      #1;
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_ready", 32'(o_ready), 1);
      chk("rst_sum",   32'(o_sum),   0);
      chk("rst_sat",   32'(o_sat),   0);
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(posedge i_clk); #1;

      // exact latency of a single standalone beat
      send(ops(1, 1), 8'hFF, 1'b0, 1'b0, 1'b1, 23'd36, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         chk("lat_early", 32'(o_valid), 0);
      end
      @(negedge i_clk);
      chk("lat_exact", 32'(o_valid), 1);
      drain();

      for (int i = 0; i < 13; i++)
         send(vecs[i].data, vecs[i].mask, vecs[i].acc_en, vecs[i].last,
              vecs[i].out, vecs[i].sum, vecs[i].sat);
      drain();

      // back-pressure: 10-beat stream with a 5-cycle stall in the middle
      fork
         begin
            for (int b = 0; b < 10; b++)
               send(ops(b*100, 3), 8'hFF, 1'b0, 1'b0, 1'b1, model(ops(b*100, 3), 8'hFF), 1'b0);
         end
         begin
            logic [SW-1:0] held;
            logic          have;
            have = 1'b0;
            held = '0;
            repeat (5) @(posedge i_clk);
            #1 i_ready = 1'b0;
            repeat (5) begin
               @(negedge i_clk);
               if (o_valid) begin
                  chk("bp_ready_low", 32'(o_ready), 0);
                  if (!have) begin
                     held = o_sum;
                     have = 1'b1;
                  end else begin
                     chk("bp_hold", 32'(o_sum), 32'(held));
                  end
               end
            end
            chk("bp_stalled", 32'(have), 1);
            @(posedge i_clk); #1 i_ready = 1'b1;
         end
      join
      drain();

      // random masked beats under random back-pressure
      begin
         logic done;
         done = 1'b0;
         fork
            begin
               for (int i = 0; i < 24; i++) begin
                  logic [DW-1:0] d;
                  logic [7:0]    m;
                  d = {$urandom(), $urandom(), $urandom(), $urandom()};
                  m = 8'($urandom());
                  send(d, m, 1'b0, 1'b0, 1'b1, model(d, m), 1'b0);
               end
               done = 1'b1;
            end
            begin
               while (!done) begin
                  @(posedge i_clk); #1;
                  i_ready = ($urandom_range(0, 3) != 0);
               end
               i_ready = 1'b1;
            end
         join
      end
      drain();

      // reset mid-stream with an open group and beats in flight
      send(ops(100, 0), 8'hFF, 1'b1, 1'b0, 1'b0, 23'd0, 1'b0);
      repeat (6) @(posedge i_clk);
      #1;
      send(ops(1, 1), 8'hFF, 1'b0, 1'b0, 1'b1, 23'd36, 1'b0);
      send(ops(2, 1), 8'hFF, 1'b0, 1'b0, 1'b1, 23'd44, 1'b0);
      send(ops(3, 1), 8'hFF, 1'b0, 1'b0, 1'b1, 23'd52, 1'b0);
      #2 i_rst = 1'b1;
      exp_q.delete();
      #1;
      chk("mid_rst_valid", 32'(o_valid), 0);
      chk("mid_rst_ready", 32'(o_ready), 1);
      chk("mid_rst_sum",   32'(o_sum),   0);
      chk("mid_rst_sat",   32'(o_sat),   0);
      @(posedge i_clk); #1 i_rst = 1'b0;
      repeat (8) @(negedge i_clk);
      @(posedge i_clk); #1;
      send(ops(1, 1), 8'hFF, 1'b1, 1'b1, 1'b1, 23'd36, 1'b0);
      drain();

      // saturation on the 20-bit instance, then a clean standalone beat
      i_data = ops(65535, 0); i_mask = 8'hFF; i_acc_en = 1'b1; i_last = 1'b0; vs_s = 1'b1;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      i_last = 1'b1;
      @(posedge i_clk); #1;
      i_data = ops(1, 1); i_acc_en = 1'b0; i_last = 1'b0;
      @(posedge i_clk); #1;
      vs_s = 1'b0;
      begin
         int n;
         n = 0;
         while (!ov_s && n < 20) begin
            @(negedge i_clk);
            n++;
         end
         chk("sat_seen", 32'(ov_s), 1);
         chk("sat_sum", 32'(osum_s), 32'h000F_FFFF);
         chk("sat_flag", 32'(osat_s), 1);
         chk("sat_ready", 32'(ordy_s), 1);
         @(negedge i_clk);
         chk("post_sat_valid", 32'(ov_s), 1);
         chk("post_sat_sum", 32'(osum_s), 36);
         chk("post_sat_flag", 32'(osat_s), 0);
      end
      repeat (4) @(posedge i_clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
